password_lock_fsm: RTL and testbench
====================================

PASSWORD_LOCK_FSM -- requirements
Module: password_lock_fsm

Interface
REQ-001 Parameter DIGITS, default 4: number of digits in the code; legal range 1..15.
REQ-002 Parameter DIG_W, default 4: width of one digit in bits.
REQ-003 Parameter PASSWORD, default 16'h1234 (width DIGITS*DIG_W): stored code; first digit in the most significant DIG_W bits.
REQ-004 Parameter MAX_FAIL, default 3: consecutive failed attempts that trigger lockout; legal range 1..15.
REQ-005 Parameter LOCK_CYCLES, default 16: lockout duration in clock cycles; must be at least 1.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 next  input  1  digit-enter strobe, level input; only its rising edge is used.
REQ-009 clear  input  1  synchronous abort/relock, active-high.
REQ-010 fsm_in  input  DIG_W  digit value, sampled on a next rising edge.
REQ-011 fsm_out_0..fsm_out_3  output  7 each, [0:6] = segments a..g  HEX0..HEX3 seven-segment patterns, active-low.
REQ-012 unlocked  output  1  high in state OPEN.
REQ-013 locked_out  output  1  high in state LOCKOUT.
REQ-014 fail_cnt  output  4  count of consecutive failed attempts.

Function
REQ-015 Edge detect: next is registered into next_q each cycle; an accepted edge is next & ~next_q; a level held high for many cycles yields exactly one edge.
REQ-016 States: ENTRY, OPEN, FAIL, LOCKOUT; the state and all outputs are registered.
REQ-017 ENTRY, on an edge:
- compare fsm_in against PASSWORD digit number idx;
- set a sticky mismatch flag on inequality;
- increment idx.
REQ-018 ENTRY, edge on the last digit (idx==DIGITS-1): the next state is decided in the same cycle from the mismatch flag combined with this digit's comparison:
- OPEN if there is no mismatch;
- else LOCKOUT if fail_cnt+1==MAX_FAIL;
- else FAIL.
In every case idx and the mismatch flag clear.
REQ-019 Entering OPEN clears fail_cnt; entering FAIL or LOCKOUT increments fail_cnt, saturating at 15.
REQ-020 OPEN: remains until clear=1 or an edge; then goes to ENTRY; fail_cnt is unchanged.
REQ-021 FAIL: remains until clear=1 or an edge; then goes to ENTRY; the exiting edge is not taken as a digit.
REQ-022 LOCKOUT:
- a down-counter loads LOCK_CYCLES-1 on entry;
- next and clear are ignored;
- at 0 it goes to ENTRY and clears fail_cnt;
- locked_out stays high for exactly LOCK_CYCLES cycles.
REQ-023 clear=1 in ENTRY zeroes idx and the mismatch flag and stays in ENTRY; fail_cnt is unchanged; clear has priority over a simultaneous edge.
REQ-024 Only edges arriving while in ENTRY enter digits.
REQ-025 Segment codes (a..g, active-low):
- digits 0-F use the standard hex glyphs;
- blank=1111111, '-'=1111110;
- O=0000001, P=0011000, E=0110000, n=1101010;
- r=1111010, L=1110001, C=0110001.
REQ-026 Display per state (HEX3..HEX0):
- ENTRY: '-','-','-', then hex of idx;
- OPEN: O,P,E,n;
- FAIL: E,r,r, then hex of fail_cnt;
- LOCKOUT: L,O,C, then hex of the upper 4 bits of the lockout counter (blank if the counter is narrower than 4 bits).
REQ-027 Digit values of fsm_in above 9 are legal and are compared bitwise.

Reset
REQ-028 While rst=0, asynchronously and regardless of clk:
- state=ENTRY;
- idx=0, mismatch=0, fail_cnt=0, next_q=0, lockout counter=0;
- unlocked=0, locked_out=0;
- display shows '-','-','-','0'.
REQ-029 Deassertion of rst is synchronised by the integrator; the block resumes at the first clk edge after rst=1.
REQ-030 Reset asserted in any state, including mid-entry or mid-lockout, discards all progress.

Verification
REQ-031 Defaults; enter edges 1,2,3,4 → unlocked=1 one cycle after the 4th edge; display "OPEn"; fail_cnt=0.
REQ-032 Enter 1,2,3,5 → FAIL; display "Err1"; fail_cnt=1; the next edge returns to ENTRY with HEX0='0'.
REQ-033 Three wrong codes in a row → LOCKOUT after the 3rd; locked_out high exactly 16 cycles; edges ignored during lockout; then ENTRY with fail_cnt=0.
REQ-034 Hold next high for 10 cycles with fsm_in=1 → idx advances by exactly 1.
REQ-035 Enter 1,2, pulse clear, then enter 1,2,3,4 → OPEN. Separately, enter 1,2, assert rst=0 mid-cycle → immediate return to the reset display; fail_cnt=0.
REQ-036 Wrong, wrong, then correct code → OPEN with fail_cnt=0; two further wrong codes → FAIL, not LOCKOUT.

Source files
------------

// File: rtl/password_lock_fsm.sv
`default_nettype none
// ============================================================================
// Module      : password_lock_fsm
// Description : Digit-by-digit password lock. Digits arrive on rising edges of
//               the next strobe. A correct code opens the lock, a wrong code
//               shows an error, and MAX_FAIL consecutive failures force a
//               timed lockout. Status is shown on four active-low 7-segment
//               displays (HEX3..HEX0).
// Revision    : 1.0 - initial release
// ============================================================================
module password_lock_fsm #(
    parameter int                        DIGITS      = 4,
    parameter int                        DIG_W       = 4,
    parameter logic [DIGITS*DIG_W-1:0]   PASSWORD    = 16'h1234,
    parameter int                        MAX_FAIL    = 3,
    parameter int                        LOCK_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             next,
    input  logic             clear,
    input  logic [DIG_W-1:0] fsm_in,
    output logic [0:6]       fsm_out_0,
    output logic [0:6]       fsm_out_1,
    output logic [0:6]       fsm_out_2,
    output logic [0:6]       fsm_out_3,
    output logic             unlocked,
    output logic             locked_out,
    output logic [3:0]       fail_cnt
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_ENTRY   = 2'd0;
    localparam logic [1:0] ST_OPEN    = 2'd1;
    localparam logic [1:0] ST_FAIL    = 2'd2;
    localparam logic [1:0] ST_LOCKOUT = 2'd3;

    // Lockout counter is just wide enough to hold LOCK_CYCLES-1
    localparam int               CNT_W      = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [3:0]       LAST_IDX   = 4'(DIGITS - 1);
    localparam logic [4:0]       FAIL_LIMIT = 5'(MAX_FAIL);

    // ------------------------------------------------------------------------
    // Segment patterns, a..g left to right, active-low
    // ------------------------------------------------------------------------
    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_DASH  = 7'b1111110;
    localparam logic [0:6] SEG_O     = 7'b0000001;
    localparam logic [0:6] SEG_P     = 7'b0011000;
    localparam logic [0:6] SEG_E     = 7'b0110000;
    localparam logic [0:6] SEG_N     = 7'b1101010;
    localparam logic [0:6] SEG_R     = 7'b1111010;
    localparam logic [0:6] SEG_L     = 7'b1110001;
    localparam logic [0:6] SEG_C     = 7'b0110001;

    // Standard hex glyph for a 4-bit value
    function automatic logic [0:6] seg_hex(input logic [3:0] val);
        logic [0:6] seg;
        case (val)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------------
    // Registered state and its next values
    // ------------------------------------------------------------------------
    logic [1:0]       state,    state_d;
    logic             next_q;
    logic [3:0]       idx,      idx_d;
    logic             mismatch, mismatch_d;
    logic [3:0]       fail_d;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_d;

    // Next values of the registered outputs
    logic             unlocked_d;
    logic             locked_out_d;
    logic [0:6]       disp0_d, disp1_d, disp2_d, disp3_d;

    // Helpers
    logic             strobe;
    logic [DIG_W-1:0] exp_digit;
    logic             digit_bad;
    logic             code_bad;
    logic [3:0]       fail_inc;
    logic             fail_hit;
    logic [3:0]       lock_hi;
    logic             lock_hi_ok;

    assign strobe    = next & ~next_q;
    assign digit_bad = (fsm_in != exp_digit);
    assign code_bad  = mismatch | digit_bad;
    assign fail_inc  = (fail_cnt == 4'hF) ? 4'hF : (fail_cnt + 4'd1);
    assign fail_hit  = (({1'b0, fail_cnt} + 5'd1) == FAIL_LIMIT);

    // Select the stored password digit addressed by idx (first digit is MSB)
    always_comb begin
        exp_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == 4'(i)) begin
                exp_digit = PASSWORD[(DIGITS-1-i)*DIG_W +: DIG_W];
            end
        end
    end

    // Lockout display shows the top nibble of the counter when it has one
    generate
        if (CNT_W >= 4) begin : g_lock_hi_wide
            assign lock_hi    = lock_cnt_d[CNT_W-1 -: 4];
            assign lock_hi_ok = 1'b1;
        end else begin : g_lock_hi_narrow
            assign lock_hi    = 4'h0;
            assign lock_hi_ok = 1'b0;
        end
    endgenerate

    // State register: FSM state, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_ENTRY;
            next_q     <= 1'b0;
            idx        <= 4'd0;
            mismatch   <= 1'b0;
            fail_cnt   <= 4'd0;
            lock_cnt   <= '0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
            fsm_out_0  <= seg_hex(4'h0);
            fsm_out_1  <= SEG_DASH;
            fsm_out_2  <= SEG_DASH;
            fsm_out_3  <= SEG_DASH;
        end else begin
            state      <= state_d;
            next_q     <= next;
            idx        <= idx_d;
            mismatch   <= mismatch_d;
            fail_cnt   <= fail_d;
            lock_cnt   <= lock_cnt_d;
            unlocked   <= unlocked_d;
            locked_out <= locked_out_d;
            fsm_out_0  <= disp0_d;
            fsm_out_1  <= disp1_d;
            fsm_out_2  <= disp2_d;
            fsm_out_3  <= disp3_d;
        end
    end

    // Next-state logic: digit entry, verdict, fail counting and lockout timing
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        mismatch_d = mismatch;
        fail_d     = fail_cnt;
        lock_cnt_d = lock_cnt;
        case (state)
            ST_ENTRY: begin
                if (clear) begin
                    // Abort has priority over a digit arriving in the same cycle
                    idx_d      = 4'd0;
                    mismatch_d = 1'b0;
                end else if (strobe) begin
                    if (idx == LAST_IDX) begin
                        // Verdict uses this digit's compare, not the stale flag
                        idx_d      = 4'd0;
                        mismatch_d = 1'b0;
                        if (!code_bad) begin
                            state_d = ST_OPEN;
                            fail_d  = 4'd0;
                        end else begin
                            fail_d = fail_inc;
                            if (fail_hit) begin
                                state_d    = ST_LOCKOUT;
                                lock_cnt_d = LOCK_LOAD;
                            end else begin
                                state_d = ST_FAIL;
                            end
                        end
                    end else begin
                        idx_d      = idx + 4'd1;
                        mismatch_d = code_bad;
                    end
                end
            end
            ST_OPEN, ST_FAIL: begin
                // The leaving edge is consumed here and never becomes a digit
                if (clear || strobe) begin
                    state_d = ST_ENTRY;
                end
            end
            default: begin
                // Lockout ignores next and clear; count down then release
                if (lock_cnt == '0) begin
                    state_d = ST_ENTRY;
                    fail_d  = 4'd0;
                end else begin
                    lock_cnt_d = lock_cnt - 1'b1;
                end
            end
        endcase
    end

    // Output logic: status flags and display glyphs derived from next state
    always_comb begin
        unlocked_d   = (state_d == ST_OPEN);
        locked_out_d = (state_d == ST_LOCKOUT);
        disp3_d      = SEG_DASH;
        disp2_d      = SEG_DASH;
        disp1_d      = SEG_DASH;
        disp0_d      = seg_hex(idx_d);
        case (state_d)
            ST_OPEN: begin
                disp3_d = SEG_O;
                disp2_d = SEG_P;
                disp1_d = SEG_E;
                disp0_d = SEG_N;
            end
            ST_FAIL: begin
                disp3_d = SEG_E;
                disp2_d = SEG_R;
                disp1_d = SEG_R;
                disp0_d = seg_hex(fail_d);
            end
            ST_LOCKOUT: begin
                disp3_d = SEG_L;
                disp2_d = SEG_O;
                disp1_d = SEG_C;
                disp0_d = lock_hi_ok ? seg_hex(lock_hi) : SEG_BLANK;
            end
            default: begin
                disp3_d = SEG_DASH;
                disp2_d = SEG_DASH;
                disp1_d = SEG_DASH;
                disp0_d = seg_hex(idx_d);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_password_lock_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_password_lock_fsm
// Description : Directed self-checking bench for password_lock_fsm with
//               default parameters (code 1,2,3,4; 3 fails; 16-cycle lockout).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_password_lock_fsm;

    // Hand-written glyphs, a..g left to right, active-low
    localparam logic [6:0] G_DASH = 7'b1111110;
    localparam logic [6:0] G_0    = 7'b0000001;
    localparam logic [6:0] G_1    = 7'b1001111;
    localparam logic [6:0] G_2    = 7'b0010010;
    localparam logic [6:0] G_3    = 7'b0000110;
    localparam logic [6:0] G_F    = 7'b0111000;
    localparam logic [6:0] G_O    = 7'b0000001;
    localparam logic [6:0] G_P    = 7'b0011000;
    localparam logic [6:0] G_E    = 7'b0110000;
    localparam logic [6:0] G_N    = 7'b1101010;
    localparam logic [6:0] G_R    = 7'b1111010;
    localparam logic [6:0] G_L    = 7'b1110001;
    localparam logic [6:0] G_C    = 7'b0110001;

    logic       clk;
    logic       rst;
    logic       next;
    logic       clear;
    logic [3:0] fsm_in;
    logic [0:6] fsm_out_0, fsm_out_1, fsm_out_2, fsm_out_3;
    logic       unlocked;
    logic       locked_out;
    logic [3:0] fail_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    password_lock_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .next       (next),
        .clear      (clear),
        .fsm_in     (fsm_in),
        .fsm_out_0  (fsm_out_0),
        .fsm_out_1  (fsm_out_1),
        .fsm_out_2  (fsm_out_2),
        .fsm_out_3  (fsm_out_3),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [6:0] h3, input logic [6:0] h2,
                            input logic [6:0] h1, input logic [6:0] h0);
        chk(tag, {fsm_out_3, fsm_out_2, fsm_out_1, fsm_out_0}, {h3, h2, h1, h0});
    endtask

    // Advance one clock and sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One digit: rising edge of next, then release
    task automatic press(input logic [3:0] d);
        fsm_in = d;
        next   = 1'b1;
        tick();
        next   = 1'b0;
        tick();
    endtask

    task automatic code4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        press(a);
        press(b);
        press(c);
        press(d);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        tick();
    endtask

    initial begin
        int cycles;
        int guard;
        rst    = 1'b1;
        next   = 1'b0;
        clear  = 1'b0;
        fsm_in = 4'h0;

        // Asynchronous reset takes effect before any clock edge
        #1 rst = 1'b0;
        #1;
        chk_disp("reset_display", G_DASH, G_DASH, G_DASH, G_0);
        chk("reset_unlocked", unlocked, 0);
        chk("reset_locked_out", locked_out, 0);
        chk("reset_fail_cnt", fail_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Correct code opens one cycle after the fourth edge
        press(4'h1);
        chk_disp("entry_idx1", G_DASH, G_DASH, G_DASH, G_1);
        press(4'h2);
        press(4'h3);
        fsm_in = 4'h4;
        next   = 1'b1;
        tick();
        chk("open_unlocked", unlocked, 1);
        chk_disp("open_display", G_O, G_P, G_E, G_N);
        chk("open_fail_cnt", fail_cnt, 0);
        next = 1'b0;
        tick();
        pulse_clear();
        chk("open_clear_unlocked", unlocked, 0);
        chk_disp("open_clear_display", G_DASH, G_DASH, G_DASH, G_0);

        // Wrong last digit gives FAIL; leaving edge is not a digit
        code4(4'h1, 4'h2, 4'h3, 4'h5);
        chk_disp("fail_display", G_E, G_R, G_R, G_1);
        chk("fail_cnt_1", fail_cnt, 1);
        chk("fail_unlocked", unlocked, 0);
        press(4'h7);
        chk_disp("fail_exit_display", G_DASH, G_DASH, G_DASH, G_0);

        // Three wrong codes from a clean start force a lockout
        do_reset();
        code4(4'h9, 4'h2, 4'h3, 4'h4);
        press(4'h0);
        code4(4'h1, 4'hA, 4'h3, 4'h4);
        chk_disp("fail2_display", G_E, G_R, G_R, G_2);
        press(4'h0);
        press(4'h1);
        press(4'h2);
        press(4'h3);
        fsm_in = 4'h5;
        next   = 1'b1;
        tick();
        chk("lock_locked_out", locked_out, 1);
        chk_disp("lock_display", G_L, G_O, G_C, G_F);
        chk("lock_fail_cnt", fail_cnt, 3);
        cycles = 1;
        guard  = 0;
        while (locked_out === 1'b1 && guard < 40) begin
            next = ~next;
            tick();
            guard++;
            if (locked_out === 1'b1) cycles++;
        end
        next = 1'b0;
        chk("lock_duration", cycles, 16);
        chk("lock_exit_fail_cnt", fail_cnt, 0);
        chk_disp("lock_exit_display", G_DASH, G_DASH, G_DASH, G_0);
        tick();

        // A long high level on next enters exactly one digit
        fsm_in = 4'h1;
        next   = 1'b1;
        repeat (10) tick();
        next = 1'b0;
        tick();
        chk_disp("held_next_idx", G_DASH, G_DASH, G_DASH, G_1);
        press(4'h2);
        press(4'h3);
        press(4'h4);
        chk("held_next_open", unlocked, 1);
        pulse_clear();

        // Clear beats a simultaneous edge, then a full code still opens
        press(4'h1);
        press(4'h2);
        clear  = 1'b1;
        next   = 1'b1;
        fsm_in = 4'h3;
        tick();
        chk_disp("clear_priority", G_DASH, G_DASH, G_DASH, G_0);
        clear = 1'b0;
        next  = 1'b0;
        tick();
        code4(4'h1, 4'h2, 4'h3, 4'h4);
        chk("clear_then_open", unlocked, 1);
        pulse_clear();

        // Reset mid-entry discards progress and fail count immediately
        code4(4'h1, 4'h2, 4'h3, 4'h3);
        chk("pre_reset_fail_cnt", fail_cnt, 1);
        press(4'h0);
        press(4'h1);
        press(4'h2);
        #2 rst = 1'b0;
        #1;
        chk_disp("midentry_reset_display", G_DASH, G_DASH, G_DASH, G_0);
        chk("midentry_reset_fail_cnt", fail_cnt, 0);
        #1 rst = 1'b1;
        tick();

        // Wrong, wrong, correct clears the count; two more wrongs only FAIL
        code4(4'h0, 4'h0, 4'h0, 4'h0);
        press(4'h0);
        code4(4'h4, 4'h3, 4'h2, 4'h1);
        chk("ww_fail_cnt", fail_cnt, 2);
        press(4'h0);
        code4(4'h1, 4'h2, 4'h3, 4'h4);
        chk("wwc_unlocked", unlocked, 1);
        chk("wwc_fail_cnt", fail_cnt, 0);
        press(4'h8);
        chk_disp("open_edge_exit", G_DASH, G_DASH, G_DASH, G_0);
        code4(4'h1, 4'h2, 4'hF, 4'h4);
        press(4'h0);
        code4(4'hE, 4'h2, 4'h3, 4'h4);
        chk("after_open_locked_out", locked_out, 0);
        chk_disp("after_open_fail_display", G_E, G_R, G_R, G_2);
        chk("after_open_fail_cnt", fail_cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
